// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition channel and its trigger front end.
// The trigger source codes are common with the ASG channel so that both blocks
// decode the same register field.
package acq_pkg;

    // Capture FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Trigger source select codes
    localparam logic [2:0] TRIG_NONE  = 3'd0;
    localparam logic [2:0] TRIG_SW    = 3'd1;
    localparam logic [2:0] TRIG_EXT_P = 3'd2;
    localparam logic [2:0] TRIG_EXT_N = 3'd3;

    // Default external trigger debounce length in clocks (~0.5 ms at 125 MHz)
    localparam int DEB_CNT_DEF = 62500;

endpackage

// File: rtl/red_pitaya_trig_deb.sv
// External trigger front end: 3-stage synchroniser followed by independent
// rising/falling edge detectors, each with its own debounce hold-off counter.
// An edge is accepted only while its counter is idle; accepting it reloads the
// counter, so bounces inside the hold-off window are dropped.
module red_pitaya_trig_deb
    import acq_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF
)(
    input  logic clk,
    input  logic srst,
    input  logic trig_ext,
    output logic ext_p,
    output logic ext_n
);

    localparam int SYNC_LEN = 3;
    localparam int CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CNT);

    logic [SYNC_LEN-1:0] sync_reg;
    logic [SYNC_LEN-1:0] sync_next;
    logic                prev_reg;
    logic [1:0]          edge_det;
    logic [CW-1:0]       deb_cnt_reg [2];
    logic [1:0]          pulse_reg;

    // Synchroniser stage inputs: stage 0 takes the pin, the rest shift along
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = trig_ext;
            end else begin : g_next
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Synchroniser chain and previous-value register for edge detection
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_LEN-1];
        end
    end

    // bit 0: rising edge, bit 1: falling edge
    assign edge_det[0] =  sync_reg[SYNC_LEN-1] & ~prev_reg;
    assign edge_det[1] = ~sync_reg[SYNC_LEN-1] &  prev_reg;

    // Per-edge debounce: accept when idle, then hold off for DEB_CNT clocks
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 2; i++) deb_cnt_reg[i] <= '0;
            pulse_reg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                pulse_reg[i] <= 1'b0;
                if (deb_cnt_reg[i] != '0) begin
                    deb_cnt_reg[i] <= deb_cnt_reg[i] - CW'(1);
                end else if (edge_det[i]) begin
                    deb_cnt_reg[i] <= DEB_LOAD;
                    pulse_reg[i]   <= 1'b1;
                end
            end
        end
    end

    assign ext_p = pulse_reg[0];
    assign ext_n = pulse_reg[1];

endmodule

// File: rtl/red_pitaya_acq_ch_seg_buf.sv
// Segmented single-channel ADC capture. After arming, every accepted trigger
// records one segment of decimated samples into a local dual-port buffer;
// segments are laid out back to back and the write pointer wraps freely.
// The bus side reads the buffer through a registered read port.
module red_pitaya_acq_ch_seg_buf
    import acq_pkg::*;
#(
    parameter int RSZ     = 14,
    parameter int N_SEG   = 4,
    parameter int DEB_CNT = DEB_CNT_DEF,
    localparam int SW     = $clog2(N_SEG) + 1
)(
    input  logic           adc_clk_i,
    input  logic           adc_rst_i,
    input  logic [13:0]    adc_dat_i,
    input  logic           trig_sw_i,
    input  logic           trig_ext_i,
    input  logic [2:0]     trig_src_i,
    input  logic           set_arm_i,
    input  logic           set_rst_i,
    input  logic [15:0]    set_dec_i,
    input  logic [RSZ-1:0] set_seg_len_i,
    input  logic [SW-1:0]  set_nseg_i,
    input  logic [RSZ-1:0] buf_addr_i,
    output logic [13:0]    buf_rdata_o,
    output logic [RSZ-1:0] wr_ptr_o,
    output logic [RSZ-1:0] seg_trig_ptr_o,
    output logic [SW-1:0]  seg_cnt_o,
    output logic           busy_o,
    output logic           seg_done_o,
    output logic           acq_done_o
);

    logic [2:0]     state_reg;
    logic [13:0]    dat_r_reg;
    logic           trig_in_reg;
    logic           ext_p;
    logic           ext_n;
    logic [15:0]    dec_sh_reg;
    logic [RSZ-1:0] len_sh_reg;
    logic [SW-1:0]  nseg_sh_reg;
    logic [15:0]    dec_cnt_reg;
    logic [RSZ-1:0] smp_cnt_reg;
    logic [RSZ-1:0] wr_ptr_reg;
    logic [RSZ-1:0] seg_trig_ptr_reg;
    logic [SW-1:0]  seg_cnt_reg;
    logic           seg_done_reg;
    logic           acq_done_reg;
    logic [13:0]    rdata_reg;
    logic [13:0]    mem [0:(1<<RSZ)-1];

    logic [15:0]    dec_eff;
    logic [RSZ-1:0] len_eff;
    logic [SW-1:0]  nseg_eff;
    logic           wr_en;
    logic           last_wr;
    logic           last_seg;
    logic           clr;

    assign clr = adc_rst_i | set_rst_i;

    // Clamp configuration to legal values before it is shadowed
    assign dec_eff  = (set_dec_i < 16'd2) ? 16'd1 : set_dec_i;
    assign len_eff  = (set_seg_len_i == '0) ? RSZ'(1) : set_seg_len_i;
    assign nseg_eff = (set_nseg_i == '0)          ? SW'(1) :
                      (set_nseg_i > SW'(N_SEG))   ? SW'(N_SEG) : set_nseg_i;

    // A write slot is any CAPTURE cycle at decimation phase 0, unless aborted
    assign wr_en    = (state_reg == ST_CAPTURE) && (dec_cnt_reg == 16'd0) &&
                      !set_rst_i && !set_arm_i;
    assign last_wr  = wr_en && (smp_cnt_reg == len_sh_reg - RSZ'(1));
    assign last_seg = (seg_cnt_reg + SW'(1)) == nseg_sh_reg;

    red_pitaya_trig_deb #(
        .DEB_CNT (DEB_CNT)
    ) u_trig_deb (
        .clk      (adc_clk_i),
        .srst     (adc_rst_i),
        .trig_ext (trig_ext_i),
        .ext_p    (ext_p),
        .ext_n    (ext_n)
    );

    // Input sample register
    always_ff @(posedge adc_clk_i) begin
        dat_r_reg <= adc_dat_i;
    end

    // Registered trigger from the selected source
    always_ff @(posedge adc_clk_i) begin
        if (clr) begin
            trig_in_reg <= 1'b0;
        end else begin
            case (trig_src_i)
                TRIG_NONE:  trig_in_reg <= 1'b0;
                TRIG_SW:    trig_in_reg <= trig_sw_i;
                TRIG_EXT_P: trig_in_reg <= ext_p;
                TRIG_EXT_N: trig_in_reg <= ext_n;
                default:    trig_in_reg <= 1'b0;
            endcase
        end
    end

    // Capture control: arm/trigger/capture sequencing, pointers and status
    always_ff @(posedge adc_clk_i) begin
        if (clr) begin
            state_reg        <= ST_IDLE;
            dec_sh_reg       <= 16'd1;
            len_sh_reg       <= RSZ'(1);
            nseg_sh_reg      <= SW'(1);
            dec_cnt_reg      <= '0;
            smp_cnt_reg      <= '0;
            wr_ptr_reg       <= '0;
            seg_trig_ptr_reg <= '0;
            seg_cnt_reg      <= '0;
            seg_done_reg     <= 1'b0;
            acq_done_reg     <= 1'b0;
        end else begin
            seg_done_reg <= 1'b0;
            acq_done_reg <= 1'b0;
            if (set_arm_i) begin
                // Arm from anywhere; an in-flight segment is dropped silently
                state_reg <= ST_ARMED;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                    end
                    ST_ARMED: begin
                        dec_sh_reg  <= dec_eff;
                        len_sh_reg  <= len_eff;
                        nseg_sh_reg <= nseg_eff;
                        wr_ptr_reg  <= '0;
                        seg_cnt_reg <= '0;
                        state_reg   <= ST_WAIT_TRIG;
                    end
                    ST_WAIT_TRIG: begin
                        if (trig_in_reg) begin
                            seg_trig_ptr_reg <= wr_ptr_reg;
                            dec_cnt_reg      <= '0;
                            smp_cnt_reg      <= '0;
                            state_reg        <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        dec_cnt_reg <= (dec_cnt_reg == dec_sh_reg - 16'd1) ?
                                       16'd0 : dec_cnt_reg + 16'd1;
                        if (wr_en) begin
                            wr_ptr_reg  <= wr_ptr_reg + RSZ'(1);
                            smp_cnt_reg <= smp_cnt_reg + RSZ'(1);
                        end
                        if (last_wr) begin
                            seg_done_reg <= 1'b1;
                            seg_cnt_reg  <= seg_cnt_reg + SW'(1);
                            if (last_seg) begin
                                acq_done_reg <= 1'b1;
                                state_reg    <= ST_DONE;
                            end else begin
                                state_reg    <= ST_WAIT_TRIG;
                            end
                        end
                    end
                    ST_DONE: begin
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Buffer write port
    always_ff @(posedge adc_clk_i) begin
        if (wr_en) mem[wr_ptr_reg] <= dat_r_reg;
    end

    // Buffer read port; a same-address write in this cycle is not yet visible
    always_ff @(posedge adc_clk_i) begin
        rdata_reg <= mem[buf_addr_i];
    end

    assign buf_rdata_o    = rdata_reg;
    assign wr_ptr_o       = wr_ptr_reg;
    assign seg_trig_ptr_o = seg_trig_ptr_reg;
    assign seg_cnt_o      = seg_cnt_reg;
    assign busy_o         = (state_reg == ST_ARMED) || (state_reg == ST_WAIT_TRIG) ||
                            (state_reg == ST_CAPTURE);
    assign seg_done_o     = seg_done_reg;
    assign acq_done_o     = acq_done_reg;

endmodule

// File: doc/red_pitaya_acq_ch_seg_buf.md
Name: red_pitaya_acq_ch_seg_buf

Overview:
Single-channel segmented ADC acquisition block, the capture-side counterpart of the multi-buffer ASG channel. Once armed, each trigger records one segment of decimated ADC samples into a local BRAM, up to N_SEG segments per acquisition. The system bus reads the buffer back and gets per-segment status for sequence-synchronised measurements.

Parameters:
RSZ, 14, buffer address width (2^RSZ samples of 14 bit)
N_SEG, 4, maximum segments per acquisition
DEB_CNT, 62500, external trigger debounce length in clocks (~0.5 ms)

Ports:
adc_clk_i  in  1  ADC clock; all logic on rising edge
adc_rst_i  in  1  reset, synchronous, active-high
adc_dat_i  in  14  signed ADC sample
trig_sw_i  in  1  software trigger pulse
trig_ext_i  in  1  external trigger, asynchronous
trig_src_i  in  3  1 sw, 2 ext rising, 3 ext falling, others none
set_arm_i  in  1  pulse: start or restart acquisition
set_rst_i  in  1  pulse: abort to IDLE, same effect as adc_rst_i except on BRAM contents
set_dec_i  in  16  decimation factor; 0 and 1 both mean every sample
set_seg_len_i  in  RSZ  samples per segment; 0 treated as 1
set_nseg_i  in  $clog2(N_SEG)+1  segments per acquisition; 0 → 1, >N_SEG → N_SEG
buf_addr_i  in  RSZ  read-back address
buf_rdata_o  out  14  read-back data, 1-cycle latency
wr_ptr_o  out  RSZ  next write address
seg_trig_ptr_o  out  RSZ  address of first sample of the most recent segment
seg_cnt_o  out  $clog2(N_SEG)+1  completed segments this acquisition
busy_o  out  1  high in ARMED/WAIT_TRIG/CAPTURE
seg_done_o  out  1  one-cycle pulse per completed segment
acq_done_o  out  1  one-cycle pulse when last segment completes

Behaviour:
- Reset or set_rst_i: state IDLE. wr_ptr_o, seg_trig_ptr_o, seg_cnt_o, busy_o, seg_done_o, acq_done_o, dec_cnt and trig_in all 0. Debounce counters cleared (adc_rst_i only). BRAM not cleared. buf_rdata_o undefined until first read.
- set_rst_i has priority over set_arm_i in the same cycle.
- Input pipeline: adc_dat_i registered once to form dat_r.
- Trigger: trig_in is registered from the source selected by trig_src_i.
  - External path: 3-FF synchroniser, then per-edge debounce; a new edge is accepted only when the counter is 0, which then loads DEB_CNT. Edge detection as in the ASG channel.
  - trig_src_i latency: sw = 1 cycle; ext = 3 sync + 2 cycles.
- FSM states IDLE, ARMED, WAIT_TRIG, CAPTURE, DONE:
  - IDLE: on set_arm_i → ARMED.
  - ARMED: one cycle. Latches dec, seg_len and nseg (clamped) into shadow registers; config changes during an acquisition have no effect. Clears wr_ptr and seg_cnt → WAIT_TRIG.
  - WAIT_TRIG: trig_in=1 → CAPTURE; seg_trig_ptr_o <= wr_ptr; dec_cnt <= 0; sample counter <= 0.
  - CAPTURE: write dat_r to BRAM[wr_ptr] each cycle dec_cnt==0, then wr_ptr+1. dec_cnt counts 0..max(dec,1)-1 and wraps. The first write happens in the first CAPTURE cycle.
  - After seg_len writes: seg_done_o pulses the next cycle and seg_cnt increments. If seg_cnt+1 == nseg → DONE with acq_done_o pulsed in the same cycle as seg_done_o; else → WAIT_TRIG.
  - DONE: holds data and pointers. set_arm_i → ARMED.
- Triggers arriving in CAPTURE, DONE or IDLE are ignored, not queued.
- set_arm_i in any non-IDLE state restarts via ARMED; pulses are not emitted for the aborted segment.
- wr_ptr wraps modulo 2^RSZ. Segments are contiguous. If the total exceeds 2^RSZ, older data is overwritten without error.
- BRAM: one write port (capture) and one read port (buf_addr_i), both on adc_clk_i.
  - Read-during-write to the same address returns old data.
  - Inference: simple dual-port, registered read.

Decomposition:
- Shared package acq_pkg: state encoding localparams, trig_src codes (TRIG_NONE/SW/EXT_P/EXT_N shared with the ASG channel), and DEB_CNT default.
- One natural sub-module: red_pitaya_trig_deb, the external trigger synchroniser and debounce producing ext_p/ext_n pulses, reusable by the ASG channel.

Test Plan:
- Basic capture: sw trigger, dec=1, seg_len=8, nseg=1, adc_dat_i ramp 0,1,2... → BRAM[0..7] hold 8 consecutive ramp values starting at the sample registered at the first CAPTURE cycle. seg_done_o and acq_done_o pulse together; wr_ptr_o=8; busy_o falls.
- Decimation: dec=4, seg_len=4, ramp input → stored values differ by 4. Capture spans 16 cycles; dec=0 gives the same result as dec=1.
- Segments and ignored triggers: nseg=3, seg_len=5, three sw triggers spaced 20 cycles apart.
  - seg_trig_ptr_o reads 0, 5 and 10 at each segment start.
  - seg_done_o pulses 3 times; acq_done_o pulses once with the third.
  - seg_cnt_o=3.
  - An extra trigger during CAPTURE is ignored.
- Wrap and clamp: RSZ=4, seg_len=10, nseg=2 → wr_ptr_o ends at 4 (20 mod 16) and BRAM[0..3] is overwritten by segment 2. nseg=7 with N_SEG=4 → exactly 4 segments.
- External trigger: trig_src=2, bouncy rising edge (glitches within 100 cycles), DEB_CNT=200 → exactly one trigger accepted. trig_src=3 captures on the falling edge only.
- Abort: set_rst_i mid-CAPTURE → IDLE next cycle; busy_o=0; no done pulses. Then set_arm_i+trigger → a normal capture restarting at address 0. Config changed mid-acquisition → no effect until the next arm.
